// File: rtl/dac_driver_pkg.sv
// dac_driver_pkg: widths, GPIO register map and field positions, FSM states
// and the lane-placement helper shared by dac_driver and dac_lut.
package dac_driver_pkg;

  localparam int NUM_LANES  = 8;
  localparam int SAMPLE_W   = 16;
  localparam int VAL_W      = 8;
  localparam int TDATA_W    = NUM_LANES * SAMPLE_W;
  localparam int FIFO_DEPTH = 16;

  localparam logic [15:0] REG_LUT_RST   = 16'd0;
  localparam logic [15:0] REG_LUT_DATA  = 16'd1;
  localparam logic [15:0] REG_LANE      = 16'd2;
  localparam logic [15:0] REG_PULSE_LEN = 16'd3;

  localparam int GPIO_ADDR_LSB = 0;
  localparam int GPIO_ADDR_W   = 16;
  localparam int GPIO_DATA_LSB = 16;
  localparam int GPIO_DATA_W   = 8;
  localparam int GPIO_WCLK_BIT = 24;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    PULSE
  } state_t;

  // Places one code into a single lane, or into every lane when bcast is set.
  function automatic logic [TDATA_W-1:0] place_lane(input logic [SAMPLE_W-1:0] code,
                                                    input logic [2:0]          lane,
                                                    input logic                bcast);
    logic [TDATA_W-1:0] word;
    word = '0;
    if (bcast) begin
      word = {NUM_LANES{code}};
    end else begin
      word[int'(lane)*SAMPLE_W +: SAMPLE_W] = code;
    end
    return word;
  endfunction

endpackage

// File: rtl/dac_lut.sv
// dac_lut: 256 x 16 DAC code table. Synchronous write from the GPIO byte-pair
// loader; registered read that only updates when the driver pops a value.
module dac_lut
  import dac_driver_pkg::*;
(
  input  logic                clk,
  input  logic                we,
  input  logic [VAL_W-1:0]    waddr,
  input  logic [SAMPLE_W-1:0] wdata,
  input  logic                re,
  input  logic [VAL_W-1:0]    raddr,
  output logic [SAMPLE_W-1:0] rdata
);

  logic [SAMPLE_W-1:0] mem [2**VAL_W];

  // No reset: table contents must survive a driver reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/dac_driver.sv
// dac_driver: buffers signed values, maps each through a GPIO-loaded LUT and
// streams it as a fixed-length pulse in one 16-bit lane of a 128-bit AXI-Stream.
// Optional macro DAC_LANE_BROADCAST_EN: lane value 8'hFF replicates into all lanes.
module dac_driver
  import dac_driver_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        gpio_in,
  input  logic [VAL_W-1:0]   val_in,
  input  logic               val_valid,
  input  logic               dac_run,
  output logic               fifo_full,
  output logic               overflow,
  output logic               busy,
  output logic [TDATA_W-1:0] m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [GPIO_ADDR_W-1:0] gpio_addr;
  logic [GPIO_DATA_W-1:0] gpio_data;
  logic [1:0]             wclk_sync;
  logic                   wclk_prev;
  logic                   gpio_wr;

  logic [VAL_W-1:0]       lut_ptr;
  logic                   lut_phase;
  logic [7:0]             lut_lo;
  logic                   lut_we;
  logic [SAMPLE_W-1:0]    lut_rdata;
  logic [7:0]             lane_sel;
  logic [7:0]             pulse_len;
  logic                   lane_bcast;
  logic                   unused_bits;

  logic [VAL_W-1:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]         wr_ptr;
  logic [PTR_W:0]         rd_ptr;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;

  state_t                 state;
  state_t                 state_nxt;
  logic [7:0]             beat_cnt;
  logic [7:0]             beat_cnt_nxt;
  logic [TDATA_W-1:0]     tdata_nxt;
  logic                   handshake;
  logic                   can_pop;

  assign gpio_addr = gpio_in[GPIO_ADDR_LSB +: GPIO_ADDR_W];
  assign gpio_data = gpio_in[GPIO_DATA_LSB +: GPIO_DATA_W];

`ifdef DAC_LANE_BROADCAST_EN
  assign lane_bcast  = (lane_sel == 8'hFF);
  assign unused_bits = ^gpio_in[31:GPIO_WCLK_BIT+1];
`else
  assign lane_bcast  = 1'b0;
  assign unused_bits = ^{gpio_in[31:GPIO_WCLK_BIT+1], lane_sel[7:3]};
`endif

  // w_clk comes from the PS domain: resynchronise, then act on its rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wclk_sync <= 2'b00;
      wclk_prev <= 1'b0;
    end else begin
      wclk_sync <= {wclk_sync[0], gpio_in[GPIO_WCLK_BIT]};
      wclk_prev <= wclk_sync[1];
    end
  end

  assign gpio_wr = wclk_sync[1] & ~wclk_prev;
  assign lut_we  = gpio_wr && (gpio_addr == REG_LUT_DATA) && lut_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      lut_ptr   <= '0;
      lut_phase <= 1'b0;
      lut_lo    <= '0;
      lane_sel  <= '0;
      pulse_len <= 8'd1;
    end else if (gpio_wr) begin
      case (gpio_addr)
        REG_LUT_RST: begin
          lut_ptr   <= '0;
          lut_phase <= 1'b0;
        end
        REG_LUT_DATA: begin
          if (!lut_phase) begin
            lut_lo    <= gpio_data;
            lut_phase <= 1'b1;
          end else begin
            lut_ptr   <= lut_ptr + 8'd1;
            lut_phase <= 1'b0;
          end
        end
        REG_LANE:      lane_sel  <= gpio_data;
        REG_PULSE_LEN: pulse_len <= gpio_data;
        default: ;
      endcase
    end
  end

  dac_lut u_lut (
    .clk   (clk),
    .we    (lut_we),
    .waddr (lut_ptr),
    .wdata ({gpio_data, lut_lo}),
    .re    (pop),
    .raddr (fifo_mem[rd_ptr[PTR_W-1:0]]),
    .rdata (lut_rdata)
  );

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push       = val_valid && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + {{PTR_W{1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr <= rd_ptr + {{PTR_W{1'b0}}, 1'b1};
      end
      if (val_valid && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[PTR_W-1:0]] <= val_in;
    end
  end

  assign handshake = m_axis_tvalid & m_axis_tready;
  assign can_pop   = dac_run & ~fifo_empty;
  assign busy      = (state != IDLE) || !fifo_empty;

  // Everything advances only on a handshaked beat; stalls hold state and data.
  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    tdata_nxt    = m_axis_tdata;
    pop          = 1'b0;
    if (handshake) begin
      unique case (state)
        IDLE: begin
          tdata_nxt = '0;
          if (can_pop) begin
            pop       = 1'b1;
            state_nxt = LOOKUP;
          end
        end
        LOOKUP: begin
          tdata_nxt    = place_lane(lut_rdata, lane_sel[2:0], lane_bcast);
          beat_cnt_nxt = (pulse_len == 8'd0) ? 8'd1 : pulse_len;
          state_nxt    = PULSE;
        end
        PULSE: begin
          beat_cnt_nxt = beat_cnt - 8'd1;
          if (beat_cnt == 8'd1) begin
            tdata_nxt = '0;
            if (can_pop) begin
              pop       = 1'b1;
              state_nxt = LOOKUP;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
    end else begin
      state         <= state_nxt;
      beat_cnt      <= beat_cnt_nxt;
      m_axis_tdata  <= tdata_nxt;
      m_axis_tvalid <= 1'b1;
    end
  end

endmodule

// File: doc/dac_driver.md
Name: dac_driver

Overview:
- Transmit-side counterpart of the ADC driver. Takes 8-bit signed spin/field values from the experiment FSM, buffers them, and maps each to a 16-bit DAC code through a GPIO-loaded 256-entry LUT.
- Emits each code as a fixed-length pulse in one lane of a 128-bit AXI-Stream to the RFSoC DAC tile.
- Between pulses, transmits zero.

Parameters:
- REG_LUT_RST, 0, GPIO address that resets the LUT write pointer and byte phase.
- REG_LUT_DATA, 1, GPIO address for a LUT data byte: low byte first, then high byte; pointer increments after the high byte.
- REG_LANE, 2, GPIO address selecting the output lane (0-7).
- REG_PULSE_LEN, 3, GPIO address for pulse length in beats (0 treated as 1).
- FIFO_DEPTH, 16, input value FIFO depth (power of 2).

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous reset, active-high.
- gpio_in  in  32  {7'b0, w_clk[24], data[23:16], addr[15:0]} from PS GPIO.
- val_in  in  8  signed value from the experiment FSM.
- val_valid  in  1  val_in qualifier; one value per cycle.
- dac_run  in  1  enables FIFO draining and pulse generation.
- fifo_full  out  1  input FIFO full.
- overflow  out  1  sticky flag: a value was dropped because the FIFO was full.
- busy  out  1  FSM not in IDLE, or FIFO not empty.
- m_axis_tdata  out  128  8 lanes x 16 bits; lane k is bits [16k+15:16k].
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  DAC ready.

Behaviour:
- Reset values:
  - All outputs 0; m_axis_tvalid is also 0 during reset.
  - Lane register = 0; pulse_len register = 1; LUT pointer = 0; byte phase = low.
  - FIFO is emptied and overflow is cleared.
  - LUT RAM contents are retained across reset.
- After reset is released, m_axis_tvalid = 1 permanently; the DAC stream is continuous.
- GPIO write path:
  - w_clk passes through a 2-FF synchronizer, then a rising-edge detect.
  - On the detected edge, addr and data are sampled and the write is applied.
  - Software holds addr/data stable for at least 4 cycles around the edge.
  - A write to an unknown address is ignored.
- LUT loading:
  - REG_LUT_DATA writes are byte-paired: the low byte is staged; the high byte commits {hi, lo} to entry[ptr], then ptr increments.
  - ptr wraps from 255 to 0.
  - A REG_LUT_RST write clears ptr and the byte phase.
- Input FIFO:
  - A push happens when val_valid = 1 and the FIFO is not full.
  - val_valid = 1 while full sets overflow and drops the value.
  - If a push and a pop occur in the same cycle while full, the push succeeds (full is evaluated before the pop).
- FSM (advances only on beats where tvalid && tready; non-handshake cycles hold state, counter and tdata):
  - IDLE: tdata = 0. If dac_run = 1 and the FIFO is not empty, pop the FIFO, present the value as the LUT address, go to LOOKUP.
  - LOOKUP: the LUT output is registered into the selected lane, other lanes are 0; load the beat counter with max(pulse_len, 1); go to PULSE.
  - PULSE:
    - tdata holds the code; the counter decrements on each handshaked beat.
    - On the last beat: if dac_run = 1 and the FIFO is not empty, pop and go to LOOKUP (back-to-back pulses, one zero beat between); otherwise go to IDLE.
  - LUT index = val_in reinterpreted as unsigned (-1 -> entry 255).
- Latency: a value pushed at cycle N into an empty FIFO, with the FSM in IDLE, dac_run = 1 and tready = 1, first appears on tdata at N+3.
- dac_run deasserted mid-pulse: the current pulse completes; no further pops.
- Lane or pulse_len written mid-pulse: takes effect at the next LOOKUP.
- rst mid-pulse: tdata is 0 the next cycle and the FIFO contents are discarded.

Optional Feature:
- Macro: DAC_LANE_BROADCAST_EN.
- Defined: REG_LANE value 8'hFF replicates the code into all 8 lanes.
- Undefined: only lane bits [2:0] are used, so 8'hFF selects lane 7.

Decomposition:
- dac_driver_pkg holds:
  - register address defaults
  - NUM_LANES = 8, SAMPLE_W = 16, VAL_W = 8
  - state enum {IDLE, LOOKUP, PULSE}
  - GPIO field bit positions (addr [15:0], data [23:16], w_clk [24])
- Sub-module dac_lut: 256x16 synchronous RAM, 1-cycle registered read, with a write port driven by the byte-pair loader.

Test Plan:
- LUT load, then a single value: load entry[i] = i*8 (signed, i = -128..127); lane = 2, pulse_len = 3, push 5 -> exactly 3 beats with lane 2 = 16'h0028, other lanes 0, then zeros; first beat at push + 3.
- Back-to-back values: push -1 then 1 with pulse_len = 1 -> beats 16'hFFF8, 0, 16'h0008, 0.
- Backpressure: tready held low for 5 cycles mid-pulse, pulse_len = 4 -> exactly 4 handshaked beats of the code; tdata stable while stalled.
- FIFO overflow: dac_run = 0, push 17 values -> fifo_full = 1 after the 16th push; overflow = 1 after the 17th; on dac_run = 1, exactly 16 pulses in push order.
- GPIO edge cases:
  - A REG_LUT_RST write mid-pair discards the staged low byte.
  - pulse_len = 0 gives 1 beat.
  - An unknown address 7 changes nothing.
- Reset mid-pulse: rst asserted on beat 2 of 4 -> tdata 0 the next cycle; fifo_full = 0 and overflow = 0; LUT still returns prior codes after reset.
